// File: rtl/seg_page_scanner.sv
// Purpose : multi-page hex digit store with auto/manual page scanning for the seg7 path.
// Latency : outputs registered; they show the page and storage as updated by the same edge.
// Backpressure: none; writes and control are accepted every cycle.
//
// Ports:
//   clock, reset          - system clock, synchronous active-high reset
//   wr_en/wr_page/wr_group/wr_data - 16-bit group write (4 hex digits, [15:12] leftmost)
//   clr                   - clear all valid flags (beats a same-cycle write)
//   auto_mode/skip_empty/hold/man_page - page selection control
//   digit_num/digit_en    - nibbles and per-digit enables of the shown page (group 0 on top)
//   page_sel/page_idx     - one-hot and binary index of the shown page
//   page_wrap             - one-cycle pulse when auto rotation lands on a page <= the previous
module seg_page_scanner #(
    parameter int NUM_PAGES = 8,
    parameter int DIGITS    = 8,
    parameter int DWELL     = 1,
    localparam int PW       = $clog2(NUM_PAGES),
    localparam int GROUPS   = DIGITS / 4,
    localparam int GW       = (GROUPS > 1) ? $clog2(GROUPS) : 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [PW-1:0]         wr_page,
    input  logic [GW-1:0]         wr_group,
    input  logic [15:0]           wr_data,
    input  logic                  clr,
    input  logic                  auto_mode,
    input  logic                  skip_empty,
    input  logic                  hold,
    input  logic [PW-1:0]         man_page,
    output logic [DIGITS*4-1:0]   digit_num,
    output logic [DIGITS-1:0]     digit_en,
    output logic [NUM_PAGES-1:0]  page_sel,
    output logic [PW-1:0]         page_idx,
    output logic                  page_wrap
);

    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;

    logic [15:0]                        mem [NUM_PAGES][GROUPS];
    logic [NUM_PAGES-1:0][GROUPS-1:0]   valid;
    logic [NUM_PAGES-1:0][GROUPS-1:0]   valid_nxt;
    logic [NUM_PAGES-1:0]               page_any;
    logic [PW-1:0]                      cur;
    logic [PW-1:0]                      cur_nxt;
    logic [PW-1:0]                      adv_pg;
    logic [PW-1:0]                      cand;
    logic                               found;
    logic [CW-1:0]                      cnt;
    logic [CW-1:0]                      cnt_nxt;
    logic                               wrap_nxt;
    logic                               wr_ok;

    wire  [DIGITS*4-1:0]                digit_num_nxt;
    wire  [DIGITS-1:0]                  digit_en_nxt;

    // Out-of-range groups and writes colliding with clr are dropped entirely.
    assign wr_ok = wr_en && !clr && (32'(wr_group) < GROUPS);

    for (genvar p = 0; p < NUM_PAGES; p++) begin : g_any
        assign page_any[p] = |valid[p];
    end

    always_comb begin
        valid_nxt = valid;
        if (clr) begin
            valid_nxt = '0;
        end else if (wr_ok) begin
            valid_nxt[wr_page][wr_group] = 1'b1;
        end
    end

    // Candidate page for the next advance. The empty-page search looks at the
    // flags as they stand before this edge and wraps around; if no other page
    // holds data the current page is kept.
    always_comb begin
        adv_pg = cur + PW'(1);
        cand   = '0;
        found  = 1'b0;
        if (skip_empty) begin
            adv_pg = cur;
            for (int k = 1; k < NUM_PAGES; k++) begin
                cand = cur + PW'(k);
                if (!found && page_any[cand]) begin
                    adv_pg = cand;
                    found  = 1'b1;
                end
            end
        end
    end

    always_comb begin
        cur_nxt  = cur;
        cnt_nxt  = cnt;
        wrap_nxt = 1'b0;
        if (!auto_mode) begin
            // Manual mode parks the dwell counter so auto resumes with a full dwell.
            cur_nxt = man_page;
            cnt_nxt = '0;
        end else if (!hold) begin
            if (cnt == CW'(DWELL - 1)) begin
                cnt_nxt  = '0;
                cur_nxt  = adv_pg;
                wrap_nxt = (adv_pg <= cur);
            end else begin
                cnt_nxt = cnt + CW'(1);
            end
        end
    end

    // Output image of the page selected for after this edge, with a same-cycle
    // write bypassed in so it shows without waiting for the array.
    for (genvar g = 0; g < GROUPS; g++) begin : g_out
        logic        vld;
        logic        hit;
        logic [15:0] dat;
        assign vld = valid_nxt[cur_nxt][g];
        assign hit = wr_ok && (wr_page == cur_nxt) && (wr_group == GW'(g));
        assign dat = hit ? wr_data : mem[cur_nxt][g];
        assign digit_num_nxt[(GROUPS-g)*16-1 -: 16] = vld ? dat : 16'h0000;
        assign digit_en_nxt[(GROUPS-g)*4-1 -: 4]    = {4{vld}};
    end

    // Data array carries no reset; the valid flags gate everything it feeds.
    always_ff @(posedge clock) begin
        if (wr_ok && !reset) begin
            mem[wr_page][wr_group] <= wr_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid     <= '0;
            cur       <= '0;
            cnt       <= '0;
            page_idx  <= '0;
            page_sel  <= '0;
            page_wrap <= 1'b0;
            digit_en  <= '0;
            digit_num <= '0;
        end else begin
            valid     <= valid_nxt;
            cur       <= cur_nxt;
            cnt       <= cnt_nxt;
            page_idx  <= cur_nxt;
            page_sel  <= {{(NUM_PAGES-1){1'b0}}, 1'b1} << cur_nxt;
            page_wrap <= wrap_nxt;
            digit_en  <= digit_en_nxt;
            digit_num <= digit_num_nxt;
        end
    end

endmodule

// File: tb/tb_seg_page_scanner.sv
module tb_seg_page_scanner;

    localparam int NP = 4;
    localparam int DG = 8;
    localparam int DW = 3;

    logic        clock = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [1:0]  wr_page;
    logic        wr_group;
    logic [15:0] wr_data;
    logic        clr;
    logic        auto_mode;
    logic        skip_empty;
    logic        hold;
    logic [1:0]  man_page;
    logic [31:0] digit_num;
    logic [7:0]  digit_en;
    logic [3:0]  page_sel;
    logic [1:0]  page_idx;
    logic        page_wrap;

    seg_page_scanner #(.NUM_PAGES(NP), .DIGITS(DG), .DWELL(DW)) dut (
        .clock      (clock),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_page    (wr_page),
        .wr_group   (wr_group),
        .wr_data    (wr_data),
        .clr        (clr),
        .auto_mode  (auto_mode),
        .skip_empty (skip_empty),
        .hold       (hold),
        .man_page   (man_page),
        .digit_num  (digit_num),
        .digit_en   (digit_en),
        .page_sel   (page_sel),
        .page_idx   (page_idx),
        .page_wrap  (page_wrap)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // Reference model: plain page/group arrays and integer page/dwell counters.
    int          m_cur;
    int          m_cnt;
    bit          m_vld [NP][2];
    logic [15:0] m_dat [NP][2];
    logic [1:0]  x_idx;
    logic [3:0]  x_sel;
    logic        x_wrap;
    logic [7:0]  x_en;
    logic [31:0] x_num;

    function automatic void model_step();
        bit has [NP];
        int nxt;
        x_wrap = 1'b0;
        if (reset) begin
            m_cur = 0;
            m_cnt = 0;
            foreach (m_vld[p, g]) m_vld[p][g] = 1'b0;
            x_idx = '0; x_sel = '0; x_en = '0; x_num = '0;
            return;
        end
        for (int p = 0; p < NP; p++) has[p] = m_vld[p][0] | m_vld[p][1];
        if (clr) begin
            foreach (m_vld[p, g]) m_vld[p][g] = 1'b0;
        end else if (wr_en) begin
            m_vld[wr_page][wr_group] = 1'b1;
            m_dat[wr_page][wr_group] = wr_data;
        end
        if (!auto_mode) begin
            m_cur = int'(man_page);
            m_cnt = 0;
        end else if (!hold) begin
            if (m_cnt == DW - 1) begin
                m_cnt = 0;
                nxt = (m_cur + 1) % NP;
                if (skip_empty) begin
                    nxt = m_cur;
                    for (int k = NP - 1; k >= 1; k--)
                        if (has[(m_cur + k) % NP]) nxt = (m_cur + k) % NP;
                end
                x_wrap = (nxt <= m_cur);
                m_cur  = nxt;
            end else begin
                m_cnt = m_cnt + 1;
            end
        end
        x_idx = 2'(m_cur);
        x_sel = 4'b0001 << m_cur;
        x_en  = '0;
        x_num = '0;
        for (int g = 0; g < 2; g++) begin
            if (m_vld[m_cur][g]) begin
                x_en  = x_en | (8'hF << ((1 - g) * 4));
                x_num = x_num | (32'(m_dat[m_cur][g]) << ((1 - g) * 16));
            end
        end
    endfunction

    // One clock: predict, clock, then compare the whole output image.
    task automatic cyc();
        model_step();
        @(posedge clock);
        #1;
        total++;
        if ({page_idx, page_sel, page_wrap, digit_en, digit_num} !==
            {x_idx, x_sel, x_wrap, x_en, x_num}) begin
            bad++;
            $display("FAIL model t=%0t got idx=%0d sel=%b wrap=%b en=%h num=%h want idx=%0d sel=%b wrap=%b en=%h num=%h",
                     $time, page_idx, page_sel, page_wrap, digit_en, digit_num,
                     x_idx, x_sel, x_wrap, x_en, x_num);
        end
    endtask

    typedef struct {
        logic        rst;
        logic        we;
        logic [1:0]  pg;
        logic        gr;
        logic [15:0] dat;
        logic        cl;
        logic        au;
        logic        sk;
        logic        ho;
        logic [1:0]  man;
        logic [1:0]  e_idx;
        logic [3:0]  e_sel;
        logic        e_wrap;
        logic [7:0]  e_en;
        logic [31:0] e_num;
    } vec_t;

    function automatic vec_t mk(logic rst, logic we, logic [1:0] pg, logic gr, logic [15:0] dat,
                                logic cl, logic au, logic sk, logic ho, logic [1:0] man,
                                logic [1:0] e_idx, logic [3:0] e_sel, logic e_wrap,
                                logic [7:0] e_en, logic [31:0] e_num);
        vec_t v;
        v.rst = rst; v.we = we; v.pg = pg; v.gr = gr; v.dat = dat;
        v.cl = cl; v.au = au; v.sk = sk; v.ho = ho; v.man = man;
        v.e_idx = e_idx; v.e_sel = e_sel; v.e_wrap = e_wrap; v.e_en = e_en; v.e_num = e_num;
        return v;
    endfunction

    vec_t vt [$];

    initial begin
        reset = 1'b1; wr_en = 1'b0; wr_page = '0; wr_group = 1'b0; wr_data = '0;
        clr = 1'b0; auto_mode = 1'b0; skip_empty = 1'b0; hold = 1'b0; man_page = '0;

        //          rst we pg gr data     cl au sk ho man  idx sel     wr en     num
        // reset held two cycles, then manual page 0
        vt.push_back(mk(1, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 0,  0, 4'b0000, 0, 8'h00, 32'h00000000));
        vt.push_back(mk(1, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 0,  0, 4'b0000, 0, 8'h00, 32'h00000000));
        vt.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 0,  0, 4'b0001, 0, 8'h00, 32'h00000000));
        // write-through on the shown page
        vt.push_back(mk(0, 1, 2, 1, 16'hBEEF, 0, 0, 0, 0, 2,  2, 4'b0100, 0, 8'h0F, 32'h0000BEEF));
        // clr beats a simultaneous write
        vt.push_back(mk(0, 1, 2, 0, 16'h1234, 1, 0, 0, 0, 2,  2, 4'b0100, 0, 8'h00, 32'h00000000));
        // fill pages 1 and 3 only
        vt.push_back(mk(0, 1, 1, 0, 16'h1111, 0, 0, 0, 0, 2,  2, 4'b0100, 0, 8'h00, 32'h00000000));
        vt.push_back(mk(0, 1, 3, 1, 16'h3333, 0, 0, 0, 0, 2,  2, 4'b0100, 0, 8'h00, 32'h00000000));
        vt.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 1,  1, 4'b0010, 0, 8'hF0, 32'h11110000));
        // skip_empty rotation 1,3,1 with 3 cycles each
        vt.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 1, 1, 0, 0,  1, 4'b0010, 0, 8'hF0, 32'h11110000));
        vt.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 1, 1, 0, 0,  1, 4'b0010, 0, 8'hF0, 32'h11110000));
        for (int i = 0; i < 3; i++)
            vt.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 1, 1, 0, 0,  3, 4'b1000, 0, 8'h0F, 32'h00003333));
        vt.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 1, 1, 0, 0,  1, 4'b0010, 1, 8'hF0, 32'h11110000));
        vt.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 1, 1, 0, 0,  1, 4'b0010, 0, 8'hF0, 32'h11110000));
        vt.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 1, 1, 0, 0,  1, 4'b0010, 0, 8'hF0, 32'h11110000));
        vt.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 1, 1, 0, 0,  3, 4'b1000, 0, 8'h0F, 32'h00003333));
        vt.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 1, 1, 0, 0,  3, 4'b1000, 0, 8'h0F, 32'h00003333));
        // hold five cycles mid-dwell, then the remaining dwell completes
        for (int i = 0; i < 5; i++)
            vt.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 1, 1, 1, 0,  3, 4'b1000, 0, 8'h0F, 32'h00003333));
        vt.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 1, 1, 0, 0,  3, 4'b1000, 0, 8'h0F, 32'h00003333));
        vt.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 1, 1, 0, 0,  1, 4'b0010, 1, 8'hF0, 32'h11110000));
        // plain rotation from page 1 to 2
        vt.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 1, 0, 0, 0,  1, 4'b0010, 0, 8'hF0, 32'h11110000));
        vt.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 1, 0, 0, 0,  1, 4'b0010, 0, 8'hF0, 32'h11110000));
        vt.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 1, 0, 0, 0,  2, 4'b0100, 0, 8'h00, 32'h00000000));
        // manual override to page 0, back to auto: full dwell before advancing
        vt.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 0,  0, 4'b0001, 0, 8'h00, 32'h00000000));
        vt.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 1, 0, 0, 0,  0, 4'b0001, 0, 8'h00, 32'h00000000));
        vt.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 1, 0, 0, 0,  0, 4'b0001, 0, 8'h00, 32'h00000000));
        for (int i = 0; i < 3; i++)
            vt.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 1, 0, 0, 0,  1, 4'b0010, 0, 8'hF0, 32'h11110000));
        for (int i = 0; i < 3; i++)
            vt.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 1, 0, 0, 0,  2, 4'b0100, 0, 8'h00, 32'h00000000));
        for (int i = 0; i < 3; i++)
            vt.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 1, 0, 0, 0,  3, 4'b1000, 0, 8'h0F, 32'h00003333));
        // 3 -> 0 wraps
        vt.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 1, 0, 0, 0,  0, 4'b0001, 1, 8'h00, 32'h00000000));
        // reset mid-rotation, then page 0 with no valid data
        vt.push_back(mk(1, 1, 0, 0, 16'hAAAA, 0, 1, 0, 0, 0,  0, 4'b0000, 0, 8'h00, 32'h00000000));
        vt.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 1, 0, 0, 0,  0, 4'b0001, 0, 8'h00, 32'h00000000));

        for (int i = 0; i < vt.size(); i++) begin
            reset = vt[i].rst; wr_en = vt[i].we; wr_page = vt[i].pg; wr_group = vt[i].gr;
            wr_data = vt[i].dat; clr = vt[i].cl; auto_mode = vt[i].au; skip_empty = vt[i].sk;
            hold = vt[i].ho; man_page = vt[i].man;
            cyc();
            total++;
            if ({page_idx, page_sel, page_wrap, digit_en, digit_num} !==
                {vt[i].e_idx, vt[i].e_sel, vt[i].e_wrap, vt[i].e_en, vt[i].e_num}) begin
                bad++;
                $display("FAIL vec%0d got idx=%0d sel=%b wrap=%b en=%h num=%h want idx=%0d sel=%b wrap=%b en=%h num=%h",
                         i, page_idx, page_sel, page_wrap, digit_en, digit_num,
                         vt[i].e_idx, vt[i].e_sel, vt[i].e_wrap, vt[i].e_en, vt[i].e_num);
            end
        end

        // Randomized traffic: sparse writes, occasional clr/reset, mostly auto mode.
        for (int n = 0; n < 3000; n++) begin
            reset      = ($urandom_range(0, 199) == 0);
            wr_en      = ($urandom_range(0, 11) == 0);
            wr_page    = 2'($urandom_range(0, 3));
            wr_group   = 1'($urandom_range(0, 1));
            wr_data    = 16'($urandom);
            clr        = ($urandom_range(0, 49) == 0);
            auto_mode  = ($urandom_range(0, 9) != 0);
            skip_empty = ($urandom_range(0, 2) != 0);
            hold       = ($urandom_range(0, 7) == 0);
            man_page   = 2'($urandom_range(0, 3));
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
